// File: rtl/student_fir_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : student_fir_tx_pkg
// Purpose  : Shared FSM state type and counter width for the FIR sample
//            transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package student_fir_tx_pkg;

    localparam int c_sent_cnt_w = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STROBE    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/student_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : student_sample_fifo
// Purpose  : Power-of-two deep sample FIFO with show-ahead read port.
// Revision : 1.0 - initial release
// ============================================================================
module student_sample_fifo #(
    parameter int DATA_SIZE  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_push,
    input  logic [DATA_SIZE-1:0]              i_push_data,
    input  logic                              i_pop,
    output logic [DATA_SIZE-1:0]              o_pop_data,
    output logic                              o_full,
    output logic                              o_empty,
    output logic [$clog2(FIFO_DEPTH):0]       o_count
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_full     = (r_count == c_cnt_w'(FIFO_DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    // A push while full is dropped even if a pop happens in the same cycle.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/student_fir_sample_tx.sv
`default_nettype none
// ============================================================================
// Module   : student_fir_sample_tx
// Purpose  : Buffers samples and hands them one at a time to a FIR filter
//            via a strobe, capturing each filter result. Optional watchdog on
//            the filter done strobe when STUDENT_FIR_TX_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module student_fir_sample_tx
    import student_fir_tx_pkg::*;
#(
    parameter int DATA_SIZE         = 16,
    parameter int DATA_SIZE_FIR_OUT = 32,
    parameter int FIFO_DEPTH        = 8,
    parameter int STROBE_LEN        = 2,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    input  logic [DATA_SIZE-1:0]         in_data_i,
    output logic                         in_ready_o,
    output logic                         valid_strobe_o,
    output logic [DATA_SIZE-1:0]         sample_o,
    input  logic                         fir_done_i,
    input  logic [DATA_SIZE_FIR_OUT-1:0] y_i,
    output logic                         res_valid_o,
    output logic [DATA_SIZE_FIR_OUT-1:0] res_data_o,
    output logic                         busy_o,
    output logic                         err_timeout_o,
    output logic [c_sent_cnt_w-1:0]      sent_cnt_o
);

    localparam int c_strb_w = $clog2(STROBE_LEN + 1);

    tx_state_t                      r_state;
    tx_state_t                      w_next_state;
    logic [c_strb_w-1:0]            r_strb_cnt;
    logic [DATA_SIZE-1:0]           r_sample;
    logic                           r_res_valid;
    logic [DATA_SIZE_FIR_OUT-1:0]   r_res_data;
    logic [c_sent_cnt_w-1:0]        r_sent_cnt;
    logic                           r_done_prev;
    logic                           w_done_rise;
    logic                           w_pop;
    logic                           w_capture;
    logic                           w_timeout;
    logic                           w_to_hit;
    logic [DATA_SIZE-1:0]           w_head;
    logic                           w_full;
    logic                           w_empty;
    logic [$clog2(FIFO_DEPTH):0]    w_fifo_count_unused;

    student_sample_fifo #(
        .DATA_SIZE  (DATA_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_push      (in_valid_i),
        .i_push_data (in_data_i),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_fifo_count_unused)
    );

    assign w_done_rise = fir_done_i && !r_done_prev;

`ifdef STUDENT_FIR_TX_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_to_w-1:0] r_to_cnt;
    logic              r_err_timeout;

    assign w_to_hit = (r_to_cnt == c_to_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_to_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_to_cnt      <= (r_state == ST_WAIT_DONE) ? r_to_cnt + 1'b1 : '0;
            r_err_timeout <= r_err_timeout | w_timeout;
        end
    end

    assign err_timeout_o = r_err_timeout;
`else
    logic w_timeout_cfg_unused;

    assign w_timeout_cfg_unused = |32'(TIMEOUT_CYCLES);
    assign w_to_hit             = 1'b0;
    assign err_timeout_o        = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (r_strb_cnt == c_strb_w'(STROBE_LEN - 1)) begin
                    w_next_state = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // A real result wins over a timeout landing on the same cycle.
                if (w_done_rise) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_GAP;
                end else if (w_to_hit) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_strb_cnt  <= '0;
            r_sample    <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_sent_cnt  <= '0;
            r_done_prev <= 1'b0;
        end else begin
            r_done_prev <= fir_done_i;
            r_res_valid <= w_capture;
            r_strb_cnt  <= (r_state == ST_STROBE) ? r_strb_cnt + 1'b1 : '0;
            if (w_pop) begin
                r_sample <= w_head;
            end
            if (w_capture) begin
                r_res_data <= y_i;
                r_sent_cnt <= r_sent_cnt + 1'b1;
            end
        end
    end

    assign in_ready_o     = !w_full;
    assign valid_strobe_o = (r_state == ST_STROBE);
    assign sample_o       = r_sample;
    assign res_valid_o    = r_res_valid;
    assign res_data_o     = r_res_data;
    assign sent_cnt_o     = r_sent_cnt;
    assign busy_o         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_student_fir_sample_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_student_fir_sample_tx
// Purpose  : Scoreboard bench for student_fir_sample_tx with a behavioural
//            filter responder. Timeout scenario adapts to
//            STUDENT_FIR_TX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_student_fir_sample_tx;

    localparam int DW    = 16;
    localparam int OW    = 32;
    localparam int DEPTH = 8;
    localparam int SLEN  = 2;
    localparam int TO    = 16;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          in_valid_i = 1'b0;
    logic [DW-1:0] in_data_i = '0;
    logic          in_ready_o;
    logic          valid_strobe_o;
    logic [DW-1:0] sample_o;
    logic          fir_done_i = 1'b0;
    logic [OW-1:0] y_i = '0;
    logic          res_valid_o;
    logic [OW-1:0] res_data_o;
    logic          busy_o;
    logic          err_timeout_o;
    logic [15:0]   sent_cnt_o;

    always #5 clk_i = ~clk_i;

    student_fir_sample_tx #(
        .DATA_SIZE         (DW),
        .DATA_SIZE_FIR_OUT (OW),
        .FIFO_DEPTH        (DEPTH),
        .STROBE_LEN        (SLEN),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .in_valid_i     (in_valid_i),
        .in_data_i      (in_data_i),
        .in_ready_o     (in_ready_o),
        .valid_strobe_o (valid_strobe_o),
        .sample_o       (sample_o),
        .fir_done_i     (fir_done_i),
        .y_i            (y_i),
        .res_valid_o    (res_valid_o),
        .res_data_o     (res_data_o),
        .busy_o         (busy_o),
        .err_timeout_o  (err_timeout_o),
        .sent_cnt_o     (sent_cnt_o)
    );

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] exp_samp_q[$];
    logic [OW-1:0] exp_res_q[$];
    logic [15:0]   exp_sent = '0;
    bit            outstanding = 1'b0;
    int            res_seen = 0;
    bit            resp_en = 1'b0;
    int            resp_dmin = 3;
    int            resp_dmax = 3;
    bit            fixed_y = 1'b0;
    logic [OW-1:0] fixed_y_val = '0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Strobe monitor: order of strobed samples, strobe width, hold, one-at-a-time.
    initial begin
        logic          prev_strb;
        int            hi_len;
        logic [DW-1:0] held;
        prev_strb = 1'b0;
        hi_len    = 0;
        held      = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_strb = 1'b0;
                hi_len    = 0;
            end else begin
                if (valid_strobe_o && !prev_strb) begin
                    if (exp_samp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: got sample_o=0x%0h expected no strobe", sample_o);
                    end else begin
                        check("strobe_sample", sample_o, exp_samp_q.pop_front());
                    end
                    check("strobe_before_done", outstanding, 1'b0);
                    outstanding = 1'b1;
                    hi_len      = 1;
                    held        = sample_o;
                end else if (valid_strobe_o) begin
                    hi_len++;
                    check("sample_stable", sample_o, held);
                end else if (prev_strb) begin
                    check("strobe_len", hi_len, SLEN);
                end
                prev_strb = valid_strobe_o;
            end
        end
    end

    // Result monitor: captured data, pulse width, running result count.
    initial begin
        logic prev_res;
        logic prev_err;
        prev_res = 1'b0;
        prev_err = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_res = 1'b0;
                prev_err = 1'b0;
            end else begin
                if (res_valid_o) begin
                    check("res_valid_width", prev_res, 1'b0);
                    if (!prev_res) begin
                        if (exp_res_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_result: got res_data_o=0x%0h expected no result", res_data_o);
                        end else begin
                            check("res_data", res_data_o, exp_res_q.pop_front());
                        end
                        exp_sent = exp_sent + 16'd1;
                        check("sent_cnt", sent_cnt_o, exp_sent);
                        outstanding = 1'b0;
                        res_seen++;
                    end
                end
                if (err_timeout_o && !prev_err) begin
                    outstanding = 1'b0;
                end
                prev_res = res_valid_o;
                prev_err = err_timeout_o;
            end
        end
    end

    // Behavioural filter: answers each strobe with a done pulse after a delay.
    initial begin
        logic          prev;
        int            d;
        logic [OW-1:0] y;
        prev = 1'b0;
        forever begin
            @(negedge clk_i);
            if (resp_en && valid_strobe_o && !prev) begin
                d = int'($urandom_range(resp_dmax, resp_dmin));
                repeat (d - 1) @(negedge clk_i);
                if (resp_en) begin
                    y = fixed_y ? fixed_y_val : OW'($urandom);
                    exp_res_q.push_back(y);
                    y_i        = y;
                    fir_done_i = 1'b1;
                    @(negedge clk_i);
                    fir_done_i = 1'b0;
                end
            end
            prev = valid_strobe_o;
        end
    end

    task automatic push(input logic [DW-1:0] d, output bit acc);
        @(negedge clk_i);
        acc        = in_ready_o;
        in_valid_i = 1'b1;
        in_data_i  = d;
        if (acc) exp_samp_q.push_back(d);
    endtask

    task automatic release_in();
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    task automatic pulse_done(input logic [OW-1:0] y, input bit expect_capture);
        @(negedge clk_i);
        y_i        = y;
        fir_done_i = 1'b1;
        if (expect_capture) exp_res_q.push_back(y);
        @(negedge clk_i);
        fir_done_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_samp_q.size() != 0 || exp_res_q.size() != 0 || outstanding || busy_o) && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        check(name, (n < 2000), 1'b1);
    endtask

    task automatic wait_in_wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!(outstanding && !valid_strobe_o) && n < 200);
        check(name, (n < 200), 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        exp_samp_q.delete();
        exp_res_q.delete();
        exp_sent    = '0;
        outstanding = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_strobe", valid_strobe_o, 1'b0);
        check("rst_sample", sample_o, '0);
        check("rst_res_valid", res_valid_o, 1'b0);
        check("rst_res_data", res_data_o, '0);
        check("rst_sent", sent_cnt_o, '0);
        check("rst_err", err_timeout_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_ready", in_ready_o, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end

    initial begin
        bit acc;
        int seen0;
        int n;

        do_reset();

        // Single sample with a known result 20 cycles after the strobe.
        resp_en     = 1'b1;
        resp_dmin   = 20;
        resp_dmax   = 20;
        fixed_y     = 1'b1;
        fixed_y_val = 32'h0000_ABCD;
        push(16'h1234, acc);
        release_in();
        check("single_accept", acc, 1'b1);
        drain("single_drain");
        check("single_res_data", res_data_o, 32'h0000_ABCD);
        check("single_sent", sent_cnt_o, 16'd1);

        // Random traffic with random filter latency and results.
        fixed_y   = 1'b0;
        resp_dmin = 3;
        resp_dmax = 12;
        for (int i = 0; i < 30; i++) begin
            push(DW'($urandom), acc);
            if ($urandom_range(1, 0) == 1) begin
                release_in();
                repeat ($urandom_range(3, 0)) @(negedge clk_i);
            end
        end
        release_in();
        drain("random_drain");

        // Fill the buffer while the transmitter waits on an unanswered strobe.
        resp_en = 1'b0;
        seen0   = res_seen;
        push(DW'($urandom), acc);
        release_in();
        wait_in_wait_done("fill_reach_wait");
        for (int i = 0; i < 9; i++) begin
            push(DW'($urandom), acc);
            check("fill_ready", acc, (i < DEPTH));
        end
        release_in();
        check("fill_full_ready", in_ready_o, 1'b0);
        resp_en = 1'b1;
        pulse_done(OW'($urandom), 1'b1);
        drain("fill_drain");
        check("fill_results", res_seen - seen0, 9);
        check("fill_ready_after", in_ready_o, 1'b1);

        // Done strobe while idle must be ignored.
        seen0 = res_seen;
        resp_en = 1'b0;
        pulse_done(OW'($urandom), 1'b0);
        repeat (4) @(negedge clk_i);
        check("idle_done_sent", sent_cnt_o, exp_sent);
        check("idle_done_results", res_seen - seen0, 0);
        check("idle_done_busy", busy_o, 1'b0);

        // Filter never answers.
        push(DW'($urandom), acc);
        release_in();
        wait_in_wait_done("to_reach_wait");
`ifdef STUDENT_FIR_TX_TIMEOUT_EN
        n = 0;
        while (!err_timeout_o && n < 100) begin
            n++;
            @(negedge clk_i);
        end
        check("timeout_cycles", n, TO);
        check("timeout_err", err_timeout_o, 1'b1);
        resp_en = 1'b1;
        push(DW'($urandom), acc);
        release_in();
        drain("timeout_next_drain");
        check("timeout_sticky", err_timeout_o, 1'b1);
`else
        n = 0;
        repeat (40) begin
            @(negedge clk_i);
            n++;
        end
        check("notimeout_err", err_timeout_o, 1'b0);
        check("notimeout_busy", busy_o, 1'b1);
        resp_en = 1'b1;
        pulse_done(OW'($urandom), 1'b1);
        drain("notimeout_drain");
`endif

        // Reset in WAIT_DONE with three samples still buffered.
        resp_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(DW'($urandom), acc);
        end
        release_in();
        wait_in_wait_done("rst_reach_wait");
        do_reset();
        repeat (10) @(negedge clk_i);
        check("rst_no_strobe", valid_strobe_o, 1'b0);
        check("rst_idle", busy_o, 1'b0);
        check("rst_no_result", res_valid_o, 1'b0);
        resp_en = 1'b1;
        push(16'hBEEF, acc);
        release_in();
        drain("rst_after_drain");
        check("rst_after_sent", sent_cnt_o, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
